// File: rtl/ristretto_exe_stage_pkg.sv
// Shared definitions for the execution stage and its data-memory counterpart.
// Holds the memory request encodings, the data-memory responder FSM states and
// the request/response structs exchanged on the dmem channel.
package ristretto_exe_stage_pkg;

  // Memory operation and access-size encodings
  localparam logic       MEM_LOAD_OP   = 1'b0;
  localparam logic       MEM_STORE_OP  = 1'b1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b01;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b10;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b11;

  // Data-memory responder FSM
  localparam int unsigned dmem_rsp_fsm_bsize = 2;

  typedef enum logic [dmem_rsp_fsm_bsize-1:0] {
    DMEM_RSP_IDLE = 2'b00,
    DMEM_RSP_BUSY = 2'b01,
    DMEM_RSP_RESP = 2'b10
  } dmem_rsp_state_e;

  typedef struct packed {
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  // Byte-write enables for an access of the given size starting at byte lane 'lane'
  function automatic logic [3:0] dmem_byte_en(logic [1:0] size, logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_SIZE_WORD: be = 4'b1111;
      MEM_SIZE_HALF: be = 4'b0011 << lane;
      MEM_SIZE_BYTE: be = 4'b0001 << lane;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ristretto_dmem_sram.sv
// Single-port word SRAM, DEPTH x 32, with per-byte write enables.
// Ports:
//   clk_i   - clock
//   en_i    - access enable; the read word and any masked write happen at this edge
//   we_i    - byte-write enables, bit i covers wdata_i[8*i +: 8]
//   addr_i  - word index
//   wdata_i - write data, already steered to its lanes
//   rdata_o - word read at the last enabled edge (contents before that edge's write)
// Contents are not reset.
module ristretto_dmem_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ristretto_dmem_responder.sv
// Memory-side responder for the core's data-memory valid/ready protocol.
// Accepts one load/store at a time, performs it on an internal byte-enabled
// word SRAM and returns load data or a store acknowledge after LATENCY extra
// cycles. Misaligned, out-of-range and illegal-size requests complete with err=1.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   dmem_req_valid_i  - request valid          dmem_req_ready_o - request accepted when high
//   dmem_req_op_i     - load (0) / store (1)   dmem_req_size_i  - word/half/byte
//   dmem_req_addr_i   - byte address           dmem_req_wdata_i - right-aligned store data
//   dmem_rsp_valid_o  - response valid         dmem_rsp_ready_i - initiator takes response
//   dmem_rsp_rdata_o  - zero-extended load data (0 for stores/errors)
//   dmem_rsp_err_o    - access error
module ristretto_dmem_responder
  import ristretto_exe_stage_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_req_valid_i,
  output logic        dmem_req_ready_o,
  input  logic        dmem_req_op_i,
  input  logic [1:0]  dmem_req_size_i,
  input  logic [31:0] dmem_req_addr_i,
  input  logic [31:0] dmem_req_wdata_i,
  output logic        dmem_rsp_valid_o,
  input  logic        dmem_rsp_ready_i,
  output logic [31:0] dmem_rsp_rdata_o,
  output logic        dmem_rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_rsp_state_e state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ready_q, valid_q, pend_q;
  logic            op_q, err_q;
  logic [1:0]      size_q, lane_q;
  dmem_rsp_t       rsp_q;

  dmem_req_t   req;
  logic        accept, rsp_hs;
  logic [31:0] offset;
  logic        in_range, req_err;
  logic [31:0] wdata_rep;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_rdata;
  logic [31:0] lane_word, rdata_ext;

  assign req = '{op: dmem_req_op_i, size: dmem_req_size_i, addr: dmem_req_addr_i,
                 wdata: dmem_req_wdata_i};

  // ready_q is only ever high in IDLE, so it doubles as the acceptance qualifier
  assign accept = ready_q & dmem_req_valid_i;
  // valid_q is only ever high in RESP
  assign rsp_hs = valid_q & dmem_rsp_ready_i;

  // Addresses below BASE_ADDR wrap to a large offset and fail the range check too
  assign offset   = req.addr - BASE_ADDR;
  assign in_range = (offset >> (AW + 2)) == 32'd0;

  always_comb begin
    req_err   = 1'b0;
    wdata_rep = req.wdata;
    case (req.size)
      MEM_SIZE_WORD: req_err = (req.addr[1:0] != 2'b00);
      MEM_SIZE_HALF: begin
        req_err   = req.addr[0];
        wdata_rep = {2{req.wdata[15:0]}};
      end
      MEM_SIZE_BYTE: wdata_rep = {4{req.wdata[7:0]}};
      default:       req_err = 1'b1;
    endcase
    if (!in_range) begin
      req_err = 1'b1;
    end
  end

  // A request coinciding with reset must not touch the array
  assign sram_en = accept & ~rst_i;
  assign sram_we = (req.op == MEM_STORE_OP && !req_err) ?
                   dmem_byte_en(req.size, req.addr[1:0]) : 4'b0000;

  ristretto_dmem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (offset[AW+1:2]),
    .wdata_i (wdata_rep),
    .rdata_o (sram_rdata)
  );

  // Lane steering of the word captured at the acceptance edge
  always_comb begin
    lane_word = sram_rdata >> {lane_q, 3'b000};
    case (size_q)
      MEM_SIZE_WORD: rdata_ext = lane_word;
      MEM_SIZE_HALF: rdata_ext = {16'h0000, lane_word[15:0]};
      MEM_SIZE_BYTE: rdata_ext = {24'h000000, lane_word[7:0]};
      default:       rdata_ext = 32'h0;
    endcase
    if (err_q || op_q == MEM_STORE_OP) begin
      rdata_ext = 32'h0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_RSP_IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = DMEM_RSP_BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = DMEM_RSP_RESP;
          end
        end
      end
      DMEM_RSP_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DMEM_RSP_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMEM_RSP_RESP: begin
        if (rsp_hs) begin
          state_d = DMEM_RSP_IDLE;
        end
      end
      default: state_d = DMEM_RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DMEM_RSP_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      op_q    <= MEM_LOAD_OP;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == DMEM_RSP_IDLE);
      // valid is registered off the RESP state, so it rises one edge after entry
      valid_q <= (state_q == DMEM_RSP_RESP) && !rsp_hs;
      pend_q  <= accept;
      if (accept) begin
        op_q   <= req.op;
        err_q  <= req_err;
        size_q <= req.size;
        lane_q <= req.addr[1:0];
      end
      if (pend_q) begin
        rsp_q <= '{rdata: rdata_ext, err: err_q};
      end
    end
  end

  assign dmem_req_ready_o = ready_q;
  assign dmem_rsp_valid_o = valid_q;
  assign dmem_rsp_rdata_o = rsp_q.rdata;
  assign dmem_rsp_err_o   = rsp_q.err;

endmodule
